// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I/RV64I multicycle datapath
module multicycle_control_unit #(
  parameter int XLEN = 64,
  parameter bit WORD_OPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     i_instr,
  input  logic            i_imem_ready,
  output logic            o_imem_req,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  input  logic            i_dmem_ready,
  input  logic            i_alu_zero,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_ir_load,
  output logic            o_pc_write,
  output logic            o_pc_src,
  output logic            o_alu_src,
  output logic            o_reg_write_en,
  output logic [1:0]      o_result_src,
  output logic [2:0]      o_imm_src,
  output logic [4:0]      o_alu_control,
  output logic [1:0]      o_mem_size,
  output logic            o_mem_unsigned,
  output logic            o_word_op,
  output logic            o_halted,
  output logic            o_illegal,
  output logic [63:0]     o_instret
);
  localparam logic WOPS = WORD_OPS && (XLEN == 64);
  localparam logic X32 = (XLEN == 32);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      r_state, w_next;
  logic [6:0]  r_opc;
  logic [2:0]  r_f3, r_imm;
  logic [4:0]  r_alu;
  logic [1:0]  r_rsrc;
  logic        r_f75, r_f70, r_alu_src, r_wop, r_halted, r_illegal;
  logic [63:0] r_instret;

  logic [6:0] w_op;
  logic [2:0] w_f3, w_imm;
  logic [4:0] w_alu;
  logic [1:0] w_rsrc;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_opr, w_opi32, w_op32, w_sys;
  logic w_known, w_illegal, w_taken, e_br, e_jmp, e_ld, e_st;
  logic w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_pc_write, w_pc_src, w_reg_write;
  logic w_unused;

  function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'd0:    alu_fn = (alt & sub_ok) ? 5'd1 : 5'd0;
      3'd1:    alu_fn = 5'd5;
      3'd2:    alu_fn = 5'd8;
      3'd3:    alu_fn = 5'd9;
      3'd4:    alu_fn = 5'd4;
      3'd5:    alu_fn = alt ? 5'd7 : 5'd6;
      3'd6:    alu_fn = 5'd3;
      default: alu_fn = 5'd2;
    endcase
  endfunction

  assign w_op    = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_lui   = w_op == 7'h37;
  assign w_auipc = w_op == 7'h17;
  assign w_jal   = w_op == 7'h6F;
  assign w_jalr  = w_op == 7'h67;
  assign w_br    = w_op == 7'h63;
  assign w_ld    = w_op == 7'h03;
  assign w_st    = w_op == 7'h23;
  assign w_opi   = w_op == 7'h13;
  assign w_opr   = w_op == 7'h33;
  assign w_opi32 = w_op == 7'h1B;
  assign w_op32  = w_op == 7'h3B;
  assign w_sys   = w_op == 7'h73;
  assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_opr | w_opi32 | w_op32 | w_sys;
  // doubleword and LWU memory ops have no meaning on a 32-bit datapath
  assign w_illegal = !w_known | ((w_opi32 | w_op32) & !WOPS)
                   | (X32 & ((w_ld & (w_f3 == 3'd3 | w_f3 == 3'd6)) | (w_st & w_f3 == 3'd3)));
  assign w_alu  = (w_opi | w_opr | w_opi32 | w_op32) ? alu_fn(w_f3, i_instr[30], w_opr | w_op32)
                : w_br ? (w_f3[2:1] == 2'b10 ? 5'd8 : w_f3[2:1] == 2'b11 ? 5'd9 : 5'd1) : 5'd0;
  assign w_imm  = w_st ? 3'd1 : w_br ? 3'd2 : (w_lui | w_auipc) ? 3'd3 : w_jal ? 3'd4 : 3'd0;
  assign w_rsrc = w_ld ? 2'd1 : (w_jal | w_jalr) ? 2'd2 : 2'd0;

  assign e_br    = r_opc == 7'h63;
  assign e_jmp   = r_opc == 7'h6F || r_opc == 7'h67;
  assign e_ld    = r_opc == 7'h03;
  assign e_st    = r_opc == 7'h23;
  assign w_taken = (r_f3[2:1] == 2'b00 ? i_alu_zero : i_alu_result[0]) ^ r_f3[0];

  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_ir_load   = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 1'b0;
    w_reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_load  = i_imem_ready;
        w_next     = i_imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: w_next = (w_sys | w_illegal) ? S_HALT : S_EXEC;
      S_EXEC: begin
        w_pc_write  = e_br | e_jmp;
        w_pc_src    = e_jmp | (e_br & w_taken);
        w_reg_write = e_jmp;
        w_next      = (e_br | e_jmp) ? S_FETCH : (e_ld | e_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = e_st;
        w_pc_write = i_dmem_ready & e_st;
        w_next     = !i_dmem_ready ? S_MEM : e_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opc     <= '0;
      r_f3      <= '0;
      r_f75     <= 1'b0;
      r_f70     <= 1'b0;
      r_alu     <= '0;
      r_imm     <= '0;
      r_alu_src <= 1'b0;
      r_rsrc    <= '0;
      r_wop     <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_pc_write) r_instret <= r_instret + 64'd1;
      if (r_state == S_DECODE) begin
        r_opc     <= w_op;
        r_f3      <= w_f3;
        r_f75     <= i_instr[30];
        r_f70     <= i_instr[25];
        r_alu     <= w_alu;
        r_imm     <= w_imm;
        r_alu_src <= !(w_opr | w_op32 | w_br);
        r_rsrc    <= w_rsrc;
        r_wop     <= (w_opi32 | w_op32) & WOPS;
        r_halted  <= w_sys;
        r_illegal <= w_illegal;
      end
    end
  end

  // everything is forced low combinationally so a reset kills an in-flight request immediately
  assign o_imem_req     = w_imem_req & !rst;
  assign o_ir_load      = w_ir_load & !rst;
  assign o_dmem_req     = w_dmem_req & !rst;
  assign o_dmem_we      = w_dmem_we & !rst;
  assign o_pc_write     = w_pc_write & !rst;
  assign o_pc_src       = w_pc_src & !rst;
  assign o_reg_write_en = w_reg_write & !rst;
  assign o_alu_src      = r_alu_src & !rst;
  assign o_result_src   = rst ? '0 : r_rsrc;
  assign o_imm_src      = rst ? '0 : r_imm;
  assign o_alu_control  = rst ? '0 : r_alu;
  assign o_mem_size     = rst ? '0 : r_f3[1:0];
  assign o_mem_unsigned = r_f3[2] & !rst;
  assign o_word_op      = r_wop & !rst;
  assign o_halted       = r_halted & !rst;
  assign o_illegal      = r_illegal & !rst;
  assign o_instret      = rst ? '0 : r_instret;

  assign w_unused = &{1'b0, i_instr[31], i_instr[29:26], i_instr[24:15], i_instr[11:7],
                      i_alu_result[XLEN-1:1], r_f75, r_f70};
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for the multicycle control FSM (64-bit and 32-bit builds)
module tb_multicycle_control_unit;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic [31:0] i_instr;
  logic        i_imem_ready, i_dmem_ready, i_alu_zero;
  logic [63:0] i_alu_result;

  logic o_imem_req, o_dmem_req, o_dmem_we, o_ir_load, o_pc_write, o_pc_src, o_alu_src, o_reg_write_en;
  logic [1:0] o_result_src, o_mem_size;
  logic [2:0] o_imm_src;
  logic [4:0] o_alu_control;
  logic o_mem_unsigned, o_word_op, o_halted, o_illegal;
  logic [63:0] o_instret;

  logic n_imem_req, n_dmem_req, n_dmem_we, n_ir_load, n_pc_write, n_pc_src, n_alu_src, n_reg_write_en;
  logic [1:0] n_result_src, n_mem_size;
  logic [2:0] n_imm_src;
  logic [4:0] n_alu_control;
  logic n_mem_unsigned, n_word_op, n_halted, n_illegal;
  logic [63:0] n_instret;

  multicycle_control_unit #(.XLEN(64), .WORD_OPS(1)) u_dut (
    .clk(clk), .rst(rst), .i_instr(i_instr), .i_imem_ready(i_imem_ready), .o_imem_req(o_imem_req),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ready(i_dmem_ready),
    .i_alu_zero(i_alu_zero), .i_alu_result(i_alu_result), .o_ir_load(o_ir_load),
    .o_pc_write(o_pc_write), .o_pc_src(o_pc_src), .o_alu_src(o_alu_src),
    .o_reg_write_en(o_reg_write_en), .o_result_src(o_result_src), .o_imm_src(o_imm_src),
    .o_alu_control(o_alu_control), .o_mem_size(o_mem_size), .o_mem_unsigned(o_mem_unsigned),
    .o_word_op(o_word_op), .o_halted(o_halted), .o_illegal(o_illegal), .o_instret(o_instret));

  multicycle_control_unit #(.XLEN(32), .WORD_OPS(1)) u_dut32 (
    .clk(clk), .rst(rst), .i_instr(i_instr), .i_imem_ready(i_imem_ready), .o_imem_req(n_imem_req),
    .o_dmem_req(n_dmem_req), .o_dmem_we(n_dmem_we), .i_dmem_ready(i_dmem_ready),
    .i_alu_zero(i_alu_zero), .i_alu_result(i_alu_result[31:0]), .o_ir_load(n_ir_load),
    .o_pc_write(n_pc_write), .o_pc_src(n_pc_src), .o_alu_src(n_alu_src),
    .o_reg_write_en(n_reg_write_en), .o_result_src(n_result_src), .o_imm_src(n_imm_src),
    .o_alu_control(n_alu_control), .o_mem_size(n_mem_size), .o_mem_unsigned(n_mem_unsigned),
    .o_word_op(n_word_op), .o_halted(n_halted), .o_illegal(n_illegal), .o_instret(n_instret));

  typedef struct {
    logic [4:0] alu;
    logic       pc_src;
    logic       rw;
    logic [1:0] rsrc;
    int         lat;
    int         mreq;
    logic       we;
    logic [1:0] msize;
    logic       munsig;
    logic       wop;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [63:0] n_ret = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // latency counts cycles from the fetch handshake to the retiring pc_write cycle
  task automatic run(input logic [31:0] ins, input logic z, input logic [63:0] res, input int stalls, input exp_t e);
    int n, lat, mreq;
    logic we;
    exp_t x;
    i_instr = ins; i_alu_zero = z; i_alu_result = res; i_imem_ready = 1;
    #1;
    n = 0;
    while (!o_ir_load && n < 20) begin @(negedge clk); n++; end
    check("fetch", n < 20, 1);
    i_dmem_ready = (stalls == 0);
    sb.push_back(e);
    lat = 0; mreq = 0; we = 0;
    do begin
      @(negedge clk);
      lat++;
      if (o_dmem_req) begin
        mreq++;
        we |= o_dmem_we;
        if (mreq > stalls) i_dmem_ready = 1;
        #1;
      end
    end while (!o_pc_write && lat < 30);
    x = sb.pop_front();
    check("latency", lat, x.lat);
    check("alu_control", o_alu_control, x.alu);
    check("pc_src", o_pc_src, x.pc_src);
    check("reg_write_en", o_reg_write_en, x.rw);
    check("result_src", o_result_src, x.rsrc);
    check("dmem_req_cycles", mreq, x.mreq);
    check("dmem_we", we, x.we);
    if (x.mreq != 0) begin
      check("mem_size", o_mem_size, x.msize);
      check("mem_unsigned", o_mem_unsigned, x.munsig);
    end
    check("word_op", o_word_op, x.wop);
    check("instret", o_instret, n_ret);
    n_ret++;
  endtask

  task automatic run_halt(input logic [31:0] ins, input logic eh, input logic ei);
    int n, s;
    i_instr = ins; i_imem_ready = 1;
    #1;
    n = 0;
    while (!o_ir_load && n < 20) begin @(negedge clk); n++; end
    check("halt_fetch", n < 20, 1);
    repeat (2) @(negedge clk);
    check("halted", o_halted, eh);
    check("illegal", o_illegal, ei);
    s = 0;
    for (int k = 0; k < 6; k++) begin
      i_imem_ready = k[0];
      @(negedge clk);
      s += o_imem_req + o_ir_load + o_pc_write + o_reg_write_en + o_dmem_req + o_dmem_we;
    end
    check("halt_quiet", s, 0);
    check("halt_instret", o_instret, n_ret);
    check("halt_hold", {o_halted, o_illegal}, {eh, ei});
  endtask

  task automatic u32_illegal(input logic [31:0] ins);
    int n, s;
    i_instr = ins; i_imem_ready = 1;
    #1;
    n = 0;
    while (!n_ir_load && n < 20) begin @(negedge clk); n++; end
    check("x32_fetch", n < 20, 1);
    repeat (2) @(negedge clk);
    check("x32_illegal", n_illegal, 1);
    check("x32_halted", n_halted, 0);
    s = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s += n_imem_req + n_ir_load + n_pc_write + n_reg_write_en + n_dmem_req;
    end
    check("x32_quiet", s, 0);
    check("x32_instret", n_instret, 0);
    check("x32_hold", n_illegal, 1);
  endtask

  task automatic do_rst();
    rst = 1; i_imem_ready = 0;
    @(negedge clk);
    check("rst_quiet", {o_imem_req, o_halted, o_illegal, o_pc_write}, 0);
    rst = 0;
    #1;
    check("rst_req", o_imem_req, 1);
    check("rst_halted", o_halted, 0);
    check("rst_instret", o_instret, 0);
    n_ret = 0;
  endtask

  initial begin
    int n;
    i_instr = 0; i_imem_ready = 0; i_dmem_ready = 0; i_alu_zero = 0; i_alu_result = 0;
    repeat (3) @(negedge clk);
    check("rst_imem_req", o_imem_req, 0);
    check("rst_alu", o_alu_control, 0);
    check("rst_instret0", o_instret, 0);
    rst = 0;
    #1;
    check("first_req", o_imem_req, 1);
    @(negedge clk);
    check("req_held", {o_imem_req, o_ir_load}, 2'b10);
    //                         alu pc rw rs lat mq we sz un wo
    run(32'h002081B3, 0, 0, 0, '{5'd0, 0, 1, 2'd0, 3, 0, 0, 2'd0, 0, 0});
    run(32'h402081B3, 0, 0, 0, '{5'd1, 0, 1, 2'd0, 3, 0, 0, 2'd0, 0, 0});
    run(32'h0020C463, 0, 1, 0, '{5'd8, 1, 0, 2'd0, 2, 0, 0, 2'd0, 0, 0});
    run(32'h0020C463, 0, 0, 0, '{5'd8, 0, 0, 2'd0, 2, 0, 0, 2'd0, 0, 0});
    run(32'h00208463, 1, 0, 0, '{5'd1, 1, 0, 2'd0, 2, 0, 0, 2'd0, 0, 0});
    run(32'h0020F463, 0, 1, 0, '{5'd9, 0, 0, 2'd0, 2, 0, 0, 2'd0, 0, 0});
    run(32'h010000EF, 0, 0, 0, '{5'd0, 1, 1, 2'd2, 2, 0, 0, 2'd0, 0, 0});
    run(32'h0000A283, 0, 0, 3, '{5'd0, 0, 1, 2'd1, 7, 4, 0, 2'd2, 0, 0});
    run(32'h0020A023, 0, 0, 0, '{5'd0, 0, 0, 2'd0, 3, 1, 1, 2'd2, 0, 0});
    run(32'h0000C283, 0, 0, 0, '{5'd0, 0, 1, 2'd1, 4, 1, 0, 2'd0, 1, 0});
    run(32'h4030D193, 0, 0, 0, '{5'd7, 0, 1, 2'd0, 3, 0, 0, 2'd0, 0, 0});
    run(32'h002081BB, 0, 0, 0, '{5'd0, 0, 1, 2'd0, 3, 0, 0, 2'd0, 0, 1});
    run_halt(32'h00000073, 1, 0);
    do_rst();
    run_halt(32'hFFFFFFFF, 0, 1);
    do_rst();
    i_instr = 32'h0020A023; i_imem_ready = 1; i_dmem_ready = 0;
    #1;
    n = 0;
    while (!o_dmem_req && n < 20) begin @(negedge clk); n++; end
    check("sw_req_to", n < 20, 1);
    check("sw_we", o_dmem_we, 1);
    rst = 1;
    #1;
    check("rst_mem_req", o_dmem_req, 0);
    check("rst_mem_we", o_dmem_we, 0);
    @(negedge clk);
    rst = 0; i_imem_ready = 0;
    #1;
    check("rst_mem_fetch", o_imem_req, 1);
    check("rst_mem_instret", o_instret, 0);
    @(negedge clk);
    check("rst_mem_idle", {o_dmem_req, o_dmem_we, o_pc_write}, 0);
    do_rst();
    u32_illegal(32'h002081BB);
    do_rst();
    u32_illegal(32'h00003083);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
